// File: rtl/mem_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_arbiter_if
//  Description : Core-side and memory-side bus bundle of the memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_rr_arbiter_if #(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4
);
    localparam int C_CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQ-1:0]      req_i;
    logic [NUM_REQ*32-1:0]   addr_i;
    logic [NUM_REQ-1:0]      we_i;
    logic [NUM_REQ*4-1:0]    be_i;
    logic [NUM_REQ*32-1:0]   wdata_i;
    logic [NUM_REQ-1:0]      gnt_o;
    logic [NUM_REQ*32-1:0]   rdata_o;
    logic [NUM_REQ-1:0]      rvalid_o;
    logic                    mem_req_o;
    logic [31:0]             mem_addr_o;
    logic                    mem_we_o;
    logic [3:0]              mem_be_o;
    logic [31:0]             mem_wdata_o;
    logic                    mem_gnt_i;
    logic [31:0]             mem_rdata_i;
    logic                    mem_rvalid_i;
    logic [C_CNT_W-1:0]      outstanding_o;
    logic                    err_o;

    // Arbiter view
    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        input  mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        output gnt_o, rdata_o, rvalid_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output outstanding_o, err_o
    );

    // Environment view (requesters plus memory controller)
    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        output mem_gnt_i, mem_rdata_i, mem_rvalid_i,
        input  gnt_o, rdata_o, rvalid_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  outstanding_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_arbiter
//  Description : Round-robin arbiter sharing one memory port among NUM_REQ
//                requesters, with in-order response routing via an ID FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_rr_arbiter_if.slave    bus
);
    localparam int IDW       = $clog2(NUM_REQ);
    localparam int C_PTR_W   = $clog2(MAX_OUTSTANDING);
    localparam int C_CNT_W   = C_PTR_W + 1;
    localparam logic [IDW-1:0]     C_LAST_RST = IDW'(NUM_REQ - 1);
    localparam logic [C_CNT_W-1:0] C_FULL     = C_CNT_W'(MAX_OUTSTANDING);

    localparam logic [0:0] S_UNLOCKED = 1'b0;
    localparam logic [0:0] S_LOCKED   = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [IDW-1:0]      r_lock_idx;
    logic [IDW-1:0]      r_last_idx;
    logic [IDW-1:0]      r_fifo [MAX_OUTSTANDING];
    logic [C_PTR_W-1:0]  r_wr_ptr;
    logic [C_PTR_W-1:0]  r_rd_ptr;
    logic [C_CNT_W-1:0]  r_count;
    logic                r_err;

    logic [IDW-1:0]      w_sel;
    logic                w_valid_sel;
    logic                w_push;
    logic                w_pop;
    logic [IDW-1:0]      w_head;

    // Rotating priority scan starting just after the last served requester
    always_comb begin
        int unsigned v_idx;
        logic        v_found;
        w_sel   = r_lock_idx;
        v_idx   = 0;
        v_found = 1'b0;
        if (r_state == S_UNLOCKED) begin
            w_sel = r_last_idx;
            for (int i = 1; i <= NUM_REQ; i++) begin
                v_idx = (int'(r_last_idx) + i) % NUM_REQ;
                if (!v_found && bus.req_i[v_idx]) begin
                    v_found = 1'b1;
                    w_sel   = IDW'(v_idx);
                end
            end
        end
    end

    // Full FIFO blocks new requests regardless of a same-cycle pop
    assign w_valid_sel = bus.req_i[w_sel] && (r_count < C_FULL);
    assign w_push      = w_valid_sel && bus.mem_gnt_i;
    assign w_pop       = bus.mem_rvalid_i && (r_count != '0);
    assign w_head      = r_fifo[r_rd_ptr];

    // Lock FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_UNLOCKED: if (w_valid_sel && !bus.mem_gnt_i) w_state_nxt = S_LOCKED;
            S_LOCKED:   if (w_push || !bus.req_i[r_lock_idx]) w_state_nxt = S_UNLOCKED;
            default:    w_state_nxt = S_UNLOCKED;
        endcase
    end

    // Lock FSM: outputs (memory port, grants, response routing)
    always_comb begin
        bus.mem_req_o   = w_valid_sel;
        bus.mem_addr_o  = '0;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        bus.gnt_o       = '0;
        bus.rvalid_o    = '0;
        bus.rdata_o     = '0;
        if (w_valid_sel) begin
            bus.mem_addr_o  = bus.addr_i[int'(w_sel)*32 +: 32];
            bus.mem_we_o    = bus.we_i[w_sel];
            bus.mem_be_o    = bus.be_i[int'(w_sel)*4 +: 4];
            bus.mem_wdata_o = bus.wdata_i[int'(w_sel)*32 +: 32];
        end
        if (w_push) begin
            bus.gnt_o[w_sel] = 1'b1;
        end
        if (w_pop) begin
            bus.rvalid_o[w_head]                 = 1'b1;
            bus.rdata_o[int'(w_head)*32 +: 32]   = bus.mem_rdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_idx <= '0;
            r_last_idx <= C_LAST_RST;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (r_state == S_UNLOCKED && w_valid_sel && !bus.mem_gnt_i) begin
                r_lock_idx <= w_sel;
            end
            if (w_push) begin
                r_last_idx <= w_sel;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
            if (bus.mem_rvalid_i && r_count == '0) begin
                r_err <= 1'b1;
            end
        end
    end

    // ID storage needs no reset: only entries between the pointers are read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

    assign bus.outstanding_o = r_count;
    assign bus.err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_rr_arbiter
//  Description : Directed self-checking bench for mem_rr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_rr_arbiter;
    localparam int NUM_REQ         = 3;
    localparam int MAX_OUTSTANDING = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUTSTANDING)) bus ();

    mem_rr_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.req_i        = '0;
        bus.we_i         = '0;
        bus.be_i         = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.addr_i  = '0;
        bus.wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.gnt_o, bus.rvalid_o, bus.mem_req_o, bus.mem_we_o} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_ctrl: got gnt=%b rvalid=%b req=%b we=%b, want all 0",
                     bus.gnt_o, bus.rvalid_o, bus.mem_req_o, bus.mem_we_o);
        end
        n_checks++;
        if ({bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o} !== '0 || bus.rdata_o !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got addr=%h be=%h wdata=%h rdata=%h, want 0",
                     bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o, bus.rdata_o);
        end
        n_checks++;
        if (bus.outstanding_o !== 3'd0 || bus.err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_status: got outstanding=%0d err=%b, want 0 0",
                     bus.outstanding_o, bus.err_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g;
        logic [2:0]  exp_v;
        logic [95:0] exp_rd;
        logic [31:0] exp_a;
        logic [31:0] d;
        for (int k = 0; k < NUM_REQ; k++) bus.addr_i[k*32 +: 32] = 32'h0000_0100 * (k + 1);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            bus.req_i        = (c < 6) ? 3'b111 : 3'b000;
            bus.mem_gnt_i    = (c < 6);
            bus.mem_rvalid_i = (c > 0);
            d                = (c > 0) ? 32'hA5A5_0000 + 32'((c - 1) % 3) : 32'h0;
            bus.mem_rdata_i  = d;
            #4;
            exp_g  = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
            exp_a  = (c < 6) ? 32'h0000_0100 * 32'((c % 3) + 1) : 32'h0;
            exp_v  = (c > 0) ? 3'(1 << ((c - 1) % 3)) : 3'b000;
            exp_rd = '0;
            if (c > 0) exp_rd[((c - 1) % 3)*32 +: 32] = d;
            n_checks++;
            if (bus.gnt_o !== exp_g || bus.mem_addr_o !== exp_a) begin
                n_errors++;
                $display("FAIL rr_grant c%0d: got gnt=%b addr=%h, want gnt=%b addr=%h",
                         c, bus.gnt_o, bus.mem_addr_o, exp_g, exp_a);
            end
            n_checks++;
            if (bus.rvalid_o !== exp_v || bus.rdata_o !== exp_rd) begin
                n_errors++;
                $display("FAIL rr_resp c%0d: got rvalid=%b rdata=%h, want rvalid=%b rdata=%h",
                         c, bus.rvalid_o, bus.rdata_o, exp_v, exp_rd);
            end
            n_checks++;
            if (bus.outstanding_o !== ((c > 0) ? 3'd1 : 3'd0)) begin
                n_errors++;
                $display("FAIL rr_count c%0d: got %0d, want %0d", c, bus.outstanding_o, (c > 0) ? 1 : 0);
            end
        end
        @(posedge clk); #1;
        drive_idle();
        #4;
        n_checks++;
        if (bus.outstanding_o !== 3'd0) begin
            n_errors++;
            $display("FAIL rr_drain: got outstanding=%0d, want 0", bus.outstanding_o);
        end
    endtask

    task automatic test_lock();
        logic [2:0]  req_t [7] = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b001, 3'b000, 3'b000};
        logic        gnt_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  eg_t  [7] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b001, 3'b000, 3'b000};
        logic [31:0] ea_t  [7] = '{32'h1000_0040, 32'h1000_0040, 32'h1000_0040, 32'h1000_0040,
                                   32'h3000_0000, 32'h0, 32'h0};
        logic [2:0]  ev_t  [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b001};
        bus.addr_i[2*32 +: 32] = 32'h1000_0040;
        bus.addr_i[0*32 +: 32] = 32'h3000_0000;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            bus.req_i        = req_t[c];
            bus.mem_gnt_i    = gnt_t[c];
            bus.mem_rvalid_i = (c >= 5);
            bus.mem_rdata_i  = 32'hC0DE_0000 + 32'(c);
            #4;
            n_checks++;
            if (bus.gnt_o !== eg_t[c] || bus.mem_addr_o !== ea_t[c] || bus.mem_req_o !== (c < 5)) begin
                n_errors++;
                $display("FAIL lock c%0d: got gnt=%b addr=%h req=%b, want gnt=%b addr=%h req=%b",
                         c, bus.gnt_o, bus.mem_addr_o, bus.mem_req_o, eg_t[c], ea_t[c], c < 5);
            end
            n_checks++;
            if (bus.rvalid_o !== ev_t[c]) begin
                n_errors++;
                $display("FAIL lock_resp c%0d: got rvalid=%b, want %b", c, bus.rvalid_o, ev_t[c]);
            end
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_full();
        logic [2:0] eg_t [10] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b000, 3'b100,
                                  3'b000, 3'b000, 3'b000, 3'b000};
        logic [2:0] ev_t [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000,
                                  3'b100, 3'b001, 3'b010, 3'b100};
        logic [2:0] eo_t [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd2, 3'd1};
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            bus.req_i        = (c < 6) ? 3'b111 : 3'b000;
            bus.mem_gnt_i    = (c < 6);
            bus.mem_rvalid_i = (c == 4) || (c >= 6);
            #4;
            n_checks++;
            if (bus.gnt_o !== eg_t[c] || bus.mem_req_o !== (c < 6 && c != 4)) begin
                n_errors++;
                $display("FAIL full_grant c%0d: got gnt=%b req=%b, want gnt=%b req=%b",
                         c, bus.gnt_o, bus.mem_req_o, eg_t[c], (c < 6 && c != 4));
            end
            n_checks++;
            if (bus.rvalid_o !== ev_t[c] || bus.outstanding_o !== eo_t[c]) begin
                n_errors++;
                $display("FAIL full_state c%0d: got rvalid=%b count=%0d, want rvalid=%b count=%0d",
                         c, bus.rvalid_o, bus.outstanding_o, ev_t[c], eo_t[c]);
            end
        end
        @(posedge clk); #1;
        drive_idle();
        #4;
        n_checks++;
        if (bus.outstanding_o !== 3'd0) begin
            n_errors++;
            $display("FAIL full_drain: got outstanding=%0d, want 0", bus.outstanding_o);
        end
    endtask

    task automatic test_mixed();
        logic [95:0] exp_rd;
        bus.addr_i[1*32 +: 32]  = 32'h2000_0004;
        bus.wdata_i[1*32 +: 32] = 32'hDEAD_BEEF;
        bus.addr_i[0*32 +: 32]  = 32'h3000_0008;
        bus.wdata_i[0*32 +: 32] = 32'h1111_2222;
        @(posedge clk); #1;
        bus.req_i     = 3'b010;
        bus.we_i      = 3'b010;
        bus.be_i      = 12'h0_3_0;
        bus.mem_gnt_i = 1'b1;
        #4;
        n_checks++;
        if (bus.gnt_o !== 3'b010 || bus.mem_we_o !== 1'b1 || bus.mem_be_o !== 4'b0011 ||
            bus.mem_addr_o !== 32'h2000_0004 || bus.mem_wdata_o !== 32'hDEAD_BEEF) begin
            n_errors++;
            $display("FAIL mixed_write: got gnt=%b we=%b be=%b addr=%h wdata=%h, want 010 1 0011 20000004 deadbeef",
                     bus.gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        @(posedge clk); #1;
        bus.req_i = 3'b001;
        bus.we_i  = 3'b000;
        bus.be_i  = 12'h0_0_F;
        #4;
        n_checks++;
        if (bus.gnt_o !== 3'b001 || bus.mem_we_o !== 1'b0 || bus.mem_be_o !== 4'b1111 ||
            bus.mem_addr_o !== 32'h3000_0008 || bus.mem_wdata_o !== 32'h1111_2222) begin
            n_errors++;
            $display("FAIL mixed_read: got gnt=%b we=%b be=%b addr=%h wdata=%h, want 001 0 1111 30000008 11112222",
                     bus.gnt_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o);
        end
        @(posedge clk); #1;
        drive_idle();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0000;
        #4;
        n_checks++;
        if (bus.rvalid_o !== 3'b010) begin
            n_errors++;
            $display("FAIL mixed_resp1: got rvalid=%b, want 010", bus.rvalid_o);
        end
        @(posedge clk); #1;
        bus.mem_rdata_i = 32'h0000_0055;
        #4;
        exp_rd = 96'h0000_0055;
        n_checks++;
        if (bus.rvalid_o !== 3'b001 || bus.rdata_o !== exp_rd) begin
            n_errors++;
            $display("FAIL mixed_resp2: got rvalid=%b rdata=%h, want 001 %h",
                     bus.rvalid_o, bus.rdata_o, exp_rd);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_empty_err();
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h1234_5678;
        #4;
        n_checks++;
        if (bus.rvalid_o !== 3'b000 || bus.rdata_o !== '0 || bus.err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_drop: got rvalid=%b rdata=%h err=%b, want 000 0 0",
                     bus.rvalid_o, bus.rdata_o, bus.err_o);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            drive_idle();
            #4;
            n_checks++;
            if (bus.err_o !== 1'b1) begin
                n_errors++;
                $display("FAIL err_sticky c%0d: got err=%b, want 1", c, bus.err_o);
            end
        end
        // Grant one request, then reset before its response arrives
        @(posedge clk); #1;
        bus.req_i     = 3'b001;
        bus.mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.err_o !== 1'b0 || bus.outstanding_o !== 3'd0) begin
            n_errors++;
            $display("FAIL async_reset: got err=%b outstanding=%0d, want 0 0", bus.err_o, bus.outstanding_o);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        bus.mem_rvalid_i = 1'b1;
        #4;
        n_checks++;
        if (bus.rvalid_o !== 3'b000) begin
            n_errors++;
            $display("FAIL stale_resp: got rvalid=%b, want 000", bus.rvalid_o);
        end
        @(posedge clk); #1;
        drive_idle();
        #4;
        n_checks++;
        if (bus.err_o !== 1'b1) begin
            n_errors++;
            $display("FAIL stale_err: got err=%b, want 1", bus.err_o);
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        n_checks++;
        if (bus.err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clear: got err=%b, want 0", bus.err_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_mixed();
        test_empty_err();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Parameterised round-robin arbiter that shares the single main-memory port among NUM_REQ requesters (index 0 = I-cache, 1 = D-cache, 2 = LSU by convention).
- Uses a req/gnt/rvalid handshake on every port.
- Locks a presented request until memory grants it.
- Tracks outstanding reads/writes in an in-order ID FIFO, so each memory rvalid is routed back to the requester that issued it.
- Sits between the core-side masters and the memory controller.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_OUTSTANDING, 4, depth of in-flight tracking FIFO (power of 2, 2..16)
IDW, derived $clog2(NUM_REQ), width of stored requester ID

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_i  in  NUM_REQ  per-requester request
addr_i  in  NUM_REQ*32  per-requester address, requester k at [32k+31:32k]
we_i  in  NUM_REQ  per-requester write enable
be_i  in  NUM_REQ*4  per-requester byte enables
wdata_i  in  NUM_REQ*32  per-requester write data
gnt_o  out  NUM_REQ  per-requester grant (one-hot or zero)
rdata_o  out  NUM_REQ*32  per-requester read data
rvalid_o  out  NUM_REQ  per-requester response valid (one-hot or zero)
mem_req_o  out  1  request to memory
mem_addr_o  out  32  memory address
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_wdata_o  out  32  memory write data
mem_gnt_i  in  1  memory accepted request this cycle
mem_rdata_i  in  32  memory read data
mem_rvalid_i  in  1  memory response valid (in order, one per accepted request, reads and writes)
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy
err_o  out  1  sticky: rvalid received with empty FIFO

Behaviour:
Reset:
- rst asynchronously clears all state: lock=0, last_idx=NUM_REQ-1, FIFO empty, count=0, err=0.
- Resulting outputs: gnt_o=0, rvalid_o=0, mem_req_o=0, mem_addr/we/be/wdata=0, rdata_o=0, outstanding_o=0, err_o=0.

Selection (combinational):
- If lock=1, sel=lock_idx.
- Otherwise sel = first k with req_i[k]=1, scanning from (last_idx+1) mod NUM_REQ upward with wrap.
- valid_sel = req_i[sel] AND count<MAX_OUTSTANDING.

Memory side (combinational):
- mem_req_o = valid_sel.
- mem_addr/we/be/wdata = fields of sel when valid_sel, else 0.

Grant:
- gnt_o[sel] = valid_sel AND mem_gnt_i; all other bits 0. Zero latency from mem_gnt_i.

Handshake (accepted = mem_req_o AND mem_gnt_i), on the clock edge:
- Push sel into FIFO; last_idx <= sel; lock <= 0.

Lock FSM, states UNLOCKED / LOCKED:
- UNLOCKED -> LOCKED when mem_req_o=1 AND mem_gnt_i=0; lock_idx <= sel. Holds the presented request stable; a higher-priority arrival cannot preempt it.
- LOCKED -> UNLOCKED on accepted.
- LOCKED -> UNLOCKED if req_i[lock_idx] drops (protocol violation); re-arbitrate next cycle.

Full FIFO:
- count==MAX_OUTSTANDING forces mem_req_o=0 and gnt_o=0, even if mem_rvalid_i pops in the same cycle. No rvalid->req combinational path.

Response:
- When mem_rvalid_i=1 and FIFO not empty: rvalid_o[head]=1, rdata_o[head]=mem_rdata_i (combinational, zero latency); pop head.
- All other rdata_o slices are 0.

Response with empty FIFO:
- rvalid is dropped, rvalid_o stays 0, err_o is set and held until rst.

Simultaneous push and pop:
- count unchanged; pointers both advance.
- Pointers wrap modulo MAX_OUTSTANDING.
- count = push - pop, saturating is never required.

Reset mid-transaction:
- In-flight IDs are discarded; later rvalids set err_o.

Test Plan:
- Reset, all req_i=0 -> all outputs 0, outstanding_o=0, err_o=0.
- req_i=3'b111 held, mem_gnt_i=1 every cycle, mem_rvalid_i one cycle after each grant -> grants cycle 0,1,2,0,1,2; each rvalid_o goes to the matching index with rdata echoed (e.g. 0xA5A5_0001 to index 1).
- req_i[2]=1 addr 0x1000_0040, mem_gnt_i=0 for 3 cycles, req_i[0] rises in cycle 1 -> mem_addr_o stays 0x1000_0040 with requester 2 locked; gnt_o=3'b100 when mem_gnt_i rises; requester 0 is granted next.
- MAX_OUTSTANDING=4, mem_gnt_i=1, no rvalid -> 4 grants, outstanding_o=4, mem_req_o=0. One rvalid -> count 3, grant resumes the following cycle.
- Mixed: requester 1 write (we=1, be=4'b0011, wdata 0xDEADBEEF) then requester 0 read -> memory sees fields unchanged; rvalid_o order is 3'b010 then 3'b001.
- mem_rvalid_i=1 with FIFO empty -> rvalid_o=0, err_o=1 and it stays 1 until rst.
